// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if
//   Bundles the keyboard pins and the decoded scan-code outputs of
//   ps2_keyboard_rx.
//   slave  : receiver side (samples the pins, drives the code outputs)
//   master : keyboard/consumer side (drives the pins, reads the code outputs)
// Signals:
//   ps2_clk, ps2_data       raw keyboard pins, asynchronous to clkin
//   code[7:0]               scan code, meaningful while code_valid is high
//   code_valid              one-cycle strobe per delivered code
//   code_ext / code_break   E0 / F0 prefix seen before code (prefix decode only)
//   parity_err, frame_err   one-cycle error strobes
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ext;
  logic       code_break;
  logic       parity_err;
  logic       frame_err;

  modport slave (
    input  ps2_clk, ps2_data,
    output code, code_valid, code_ext, code_break, parity_err, frame_err
  );

  modport master (
    output ps2_clk, ps2_data,
    input  code, code_valid, code_ext, code_break, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Turns the PS/2 keyboard clock/data stream into scan-code bytes: 2-FF
//   synchronizers, a run-length clock glitch filter, an 11-bit frame FSM with
//   odd-parity and stop-bit checking, and a mid-frame inactivity timeout.
//   Optional make/break prefix decoding is enabled by defining the macro
//   PS2_BREAK_DECODE_EN; without it every good byte (E0/F0 included) strobes
//   code_valid and code_ext/code_break stay 0.
// Parameters:
//   FILTER_LEN   consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYC  idle clkin cycles tolerated mid-frame before aborting
// Ports:
//   clkin   system clock, all logic on posedge
//   rst     asynchronous active-low reset
//   ps2_if  slave modport of ps2_keyboard_rx_if (pins in, code/strobes out)
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data 0 on a sample event)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | waiting for the parity bit
//   ST_STOP   | waiting for the stop bit; frame result decided here
module ps2_keyboard_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clkin,
  input  logic             rst,
  ps2_keyboard_rx_if.slave ps2_if
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LOAD  = TCW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // synchronizers and clock filter
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           sample_ev;

  // frame FSM
  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           flag_ext_q, flag_ext_d, flag_brk_q, flag_brk_d;

  // registered outputs
  logic [7:0]     code_q, code_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s1_q    <= ps2_if.ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_if.ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  // The run counter only advances while the synchronized clock disagrees with
  // the filtered level; any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // The sample event is the first cycle the filtered clock reads low.
  assign sample_ev = filt_prev_q & ~filt_q;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= TMO_LOAD;
      flag_ext_q <= 1'b0;
      flag_brk_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      flag_ext_q <= flag_ext_d;
      flag_brk_q <= flag_brk_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    flag_ext_d = flag_ext_q;
    flag_brk_d = flag_brk_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    // Down-counter: reloaded on every sample event, terminal count at zero.
    if (state_q == ST_IDLE || sample_ev) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - TCW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sample_ev && !dat_s2_q) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_ev) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (sample_ev) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_ev) begin
          state_d = ST_IDLE;
          if (!dat_s2_q) begin
            ferr_d     = 1'b1;
            flag_ext_d = 1'b0;
            flag_brk_d = 1'b0;
          end else if (!(^{shift_q, par_q})) begin
            perr_d     = 1'b1;
            flag_ext_d = 1'b0;
            flag_brk_d = 1'b0;
          end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (shift_q == 8'hE0) begin
              flag_ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              flag_brk_d = 1'b1;
            end else begin
              valid_d    = 1'b1;
              code_d     = shift_q;
              ext_d      = flag_ext_q;
              brk_d      = flag_brk_q;
              flag_ext_d = 1'b0;
              flag_brk_d = 1'b0;
            end
`else
            // Prefix flags never set in this build, so ext_q/brk_q stay 0.
            valid_d = 1'b1;
            code_d  = shift_q;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A sample event in the terminal-count cycle keeps the frame alive.
    if (state_q != ST_IDLE && !sample_ev && tmo_q == '0) begin
      state_d    = ST_IDLE;
      ferr_d     = 1'b1;
      flag_ext_d = 1'b0;
      flag_brk_d = 1'b0;
    end
  end

  assign ps2_if.code       = code_q;
  assign ps2_if.code_valid = valid_q;
  assign ps2_if.code_ext   = ext_q;
  assign ps2_if.code_break = brk_q;
  assign ps2_if.parity_err = perr_q;
  assign ps2_if.frame_err  = ferr_q;

endmodule
